mem_port_arbiter: RTL

//  Shares the single-ported unified memory between the instruction-fetch requester (read-only)
//  and the data requester driven by the memRead/memWrite control signals.
//  A 4-state FSM sequences one memory access at a time, returns read data and a valid pulse
//  to the winning requester, and exposes stall levels to the pipeline.
//  A watchdog flags accesses that never complete. Sits between the core datapath and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_watchdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State encodings are fixed 2-bit values so they read the same in waveforms and the core headers.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

  function automatic logic is_grant(arb_state_e s);
    return (s == ARB_GRANT_I) || (s == ARB_GRANT_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshake signals around the arbiter.
// slave = the arbiter's view; master = the surrounding core plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              bus_error;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_error
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_error
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts enabled cycles and flags the TIMEOUT-th one.
// The count parks at TIMEOUT-1 so it cannot wrap if the owner ignores the flag.
module mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, one access at a time.
// All bus-facing outputs are registered; only the stall levels are combinational.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_b,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_valid_q,  if_valid_d;
  logic              d_valid_q,   d_valid_d;
  logic              bus_error_q, bus_error_d;
  logic [SW-1:0]     starve_q,    starve_d;

  logic wd_enable;
  logic wd_expired;
  logic grant_d;

  assign wd_enable = is_grant(state_q);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (!wd_enable),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Data wins a tie (it belongs to the older instruction) until fetch has waited STARVE_LIMIT grants.
  assign grant_d = bus.d_req && (!bus.if_req || (starve_q < STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_error_d = bus_error_q;
    starve_d    = starve_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d     = ARB_GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (!bus.if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (bus.if_req) begin
          state_d    = ARB_GRANT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          starve_d   = '0;
        end
      end

      ARB_GRANT_I, ARB_GRANT_D: begin
        // A completing mem_ready takes priority over a watchdog expiring in the same cycle.
        if (bus.mem_ready || wd_expired) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!bus.mem_ready) begin
            bus_error_d = 1'b1;
          end
          if (state_q == ARB_GRANT_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            d_valid_d = 1'b1;
            // Stores leave the load-data register untouched, even on timeout.
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
            end
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_error_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_error_q <= bus_error_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.bus_error = bus_error_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule
